// File: rtl/sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// sprite_rom_arbiter
//
// Shares one single-port, registered-read sprite pixel ROM between the
// background tile renderer (BG) and the moving-object overlay fetcher (OBJ).
// At most one read is granted per cycle. The grant owner is tagged and the tag
// travels through a ROM_LAT-deep pipeline, so each requester sees a one-cycle
// rvalid strobe exactly when its word appears on rd_data.
//
// Priority: BG wins during active video, OBJ wins during blanking. If OBJ is
// denied STARVE_MAX cycles in a row, the next cycle is a forced OBJ slot
// (FORCE_OBJ) that overrides the blank-based priority.
//
// Ports:
//   clk         system/pixel clock
//   rst         synchronous reset, active low
//   blank       1 during horizontal or vertical blanking
//   bg_req      BG read request, held with bg_addr stable until granted
//   bg_addr     BG read address
//   bg_gnt      BG request accepted this cycle
//   bg_rvalid   rd_data holds the BG read result
//   obj_req     OBJ read request, same hold rule as bg_req
//   obj_addr    OBJ read address
//   obj_gnt     OBJ request accepted this cycle
//   obj_rvalid  rd_data holds the OBJ read result
//   rom_addr    address to the sprite ROM (holds when nothing is granted)
//   rom_data    sprite ROM read data
//   rd_data     shared return data, pass-through of rom_data
//   starve_cnt  current count of consecutive OBJ denials
// -----------------------------------------------------------------------------
module sprite_rom_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              blank,
    input  logic              bg_req,
    input  logic [ADDR_W-1:0] bg_addr,
    output logic              bg_gnt,
    output logic              bg_rvalid,
    input  logic              obj_req,
    input  logic [ADDR_W-1:0] obj_addr,
    output logic              obj_gnt,
    output logic              obj_rvalid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [7:0]        starve_cnt
);

    typedef enum logic [0:0] {
        ST_NORMAL    = 1'b0,
        ST_FORCE_OBJ = 1'b1
    } state_t;

    localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

    state_t            state_q;
    state_t            state_d;
    logic [7:0]        starve_q;
    logic [7:0]        starve_d;
    logic [7:0]        starve_inc;
    logic [ADDR_W-1:0] addr_hold_q;
    logic              bg_gnt_c;
    logic              obj_gnt_c;

    // Tag pipeline: bit 1 = BG owns the read, bit 0 = OBJ owns the read.
    logic [1:0]        tag_pipe [ROM_LAT];

    // -------------------------------------------------------------------------
    // Grant decision. Purely combinational so the winner's address reaches the
    // ROM in the same cycle the request is seen. Reset masks every grant.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves one unassigned would infer a latch.
        bg_gnt_c  = 1'b0;
        obj_gnt_c = 1'b0;
        if (rst) begin
            if (state_q == ST_FORCE_OBJ) begin
                // Forced slot belongs to OBJ only; if OBJ withdrew, the slot
                // goes unused rather than being handed to BG.
                obj_gnt_c = obj_req;
            end else if (blank) begin
                obj_gnt_c = obj_req;
                bg_gnt_c  = bg_req & ~obj_req;
            end else begin
                bg_gnt_c  = bg_req;
                obj_gnt_c = obj_req & ~bg_req;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Starvation counter and FSM next state.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = ST_NORMAL;
        starve_d   = 8'd0;
        starve_inc = (starve_q == 8'hFF) ? 8'hFF : starve_q + 8'd1;
        // FORCE_OBJ always lasts one cycle and always clears the count,
        // whether or not OBJ was still requesting.
        if (state_q == ST_NORMAL && obj_req && !obj_gnt_c) begin
            starve_d = starve_inc;
            if (starve_inc == STARVE_LIMIT) begin
                state_d = ST_FORCE_OBJ;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q     <= ST_NORMAL;
            starve_q    <= 8'd0;
            addr_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (bg_gnt_c) begin
                addr_hold_q <= bg_addr;
            end else if (obj_gnt_c) begin
                addr_hold_q <= obj_addr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Return-path tag pipeline.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: this small array is reset on purpose: a stale tag would raise
        // a spurious rvalid, so reads in flight at reset must be dropped.
        if (!rst) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                tag_pipe[i] <= 2'b00;
            end
        end else begin
            tag_pipe[0] <= {bg_gnt_c, obj_gnt_c};
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The ROM address follows the winner and otherwise holds the last
    // granted address so the ROM input does not toggle on idle cycles.
    // -------------------------------------------------------------------------
    always_comb begin
        rom_addr = '0;
        if (rst) begin
            if (bg_gnt_c) begin
                rom_addr = bg_addr;
            end else if (obj_gnt_c) begin
                rom_addr = obj_addr;
            end else begin
                rom_addr = addr_hold_q;
            end
        end
    end

    assign bg_gnt     = bg_gnt_c;
    assign obj_gnt    = obj_gnt_c;
    assign bg_rvalid  = rst & tag_pipe[ROM_LAT-1][1];
    assign obj_rvalid = rst & tag_pipe[ROM_LAT-1][0];
    assign rd_data    = rom_data;
    assign starve_cnt = starve_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sprite_rom_arbiter
//
// Directed stimulus against sprite_rom_arbiter (ROM_LAT=2, STARVE_MAX=8) with a
// behavioural ROM, a transaction-level reference model checked every cycle,
// and hand-computed literal expectations for the key scenarios.
// ROM contents: word(a) = a[15:0] ^ a[17:16] ^ 16'hA5A5.
// -----------------------------------------------------------------------------
module tb_sprite_rom_arbiter;

    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int LAT = 2;
    localparam int SMX = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          blank;
    logic          bg_req;
    logic [AW-1:0] bg_addr;
    logic          bg_gnt;
    logic          bg_rvalid;
    logic          obj_req;
    logic [AW-1:0] obj_addr;
    logic          obj_gnt;
    logic          obj_rvalid;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic [DW-1:0] rd_data;
    logic [7:0]    starve_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    sprite_rom_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .ROM_LAT   (LAT),
        .STARVE_MAX(SMX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .blank     (blank),
        .bg_req    (bg_req),
        .bg_addr   (bg_addr),
        .bg_gnt    (bg_gnt),
        .bg_rvalid (bg_rvalid),
        .obj_req   (obj_req),
        .obj_addr  (obj_addr),
        .obj_gnt   (obj_gnt),
        .obj_rvalid(obj_rvalid),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .rd_data   (rd_data),
        .starve_cnt(starve_cnt)
    );

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return a[15:0] ^ {14'd0, a[17:16]} ^ 16'hA5A5;
    endfunction

    // Behavioural ROM: data appears LAT cycles after the address is presented.
    logic [AW-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_word(rom_pipe[LAT-1]);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model: tracks consecutive OBJ denials, the last granted
    // address and a queue of reads due back at a given cycle.
    // -------------------------------------------------------------------------
    typedef struct {
        int            due;
        bit            is_bg;
        logic [AW-1:0] addr;
    } rd_t;

    rd_t           pend[$];
    int            m_den  = 0;
    logic [AW-1:0] m_last = '0;

    always @(negedge clk) begin : compare
        bit            force_now;
        bit            e_bg, e_obj, e_brv, e_orv;
        logic [AW-1:0] e_addr;
        logic [AW-1:0] r_addr;
        if (model_on) begin
            force_now = (m_den == SMX);
            e_bg = 1'b0; e_obj = 1'b0; e_brv = 1'b0; e_orv = 1'b0;
            r_addr = '0;
            if (rst) begin
                if (force_now) begin
                    e_obj = obj_req;
                end else if (blank) begin
                    e_obj = obj_req;
                    e_bg  = bg_req && !obj_req;
                end else begin
                    e_bg  = bg_req;
                    e_obj = obj_req && !bg_req;
                end
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    e_brv  = pend[0].is_bg;
                    e_orv  = !pend[0].is_bg;
                    r_addr = pend[0].addr;
                    void'(pend.pop_front());
                end
            end
            e_addr = !rst ? '0 : e_bg ? bg_addr : e_obj ? obj_addr : m_last;

            check("bg_gnt",     bg_gnt,     e_bg);
            check("obj_gnt",    obj_gnt,    e_obj);
            check("rom_addr",   rom_addr,   e_addr);
            check("bg_rvalid",  bg_rvalid,  e_brv);
            check("obj_rvalid", obj_rvalid, e_orv);
            check("starve_cnt", starve_cnt, m_den);
            if (e_brv || e_orv) check("rd_data", rd_data, rom_word(r_addr));

            // Advance the model to the upcoming clock edge.
            if (!rst) begin
                m_den  = 0;
                m_last = '0;
                pend.delete();
            end else begin
                if (e_bg || e_obj) begin
                    m_last = e_addr;
                    pend.push_back('{due: cyc + LAT, is_bg: e_bg, addr: e_addr});
                end
                if (force_now || !obj_req || e_obj) m_den = 0;
                else if (m_den < 255) m_den++;
            end
        end
        cyc++;
    end

    // Apply one cycle of inputs just after the edge, return at mid-cycle.
    task automatic cycle_in(input logic r, input logic b, input logic br, input logic [AW-1:0] ba,
                            input logic orq, input logic [AW-1:0] oa);
        @(posedge clk);
        #1;
        rst = r; blank = b; bg_req = br; bg_addr = ba; obj_req = orq; obj_addr = oa;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; blank = 1'b0; bg_req = 1'b1; bg_addr = '0; obj_req = 1'b1; obj_addr = '0;
        @(posedge clk);
        #1;
        model_on = 1'b1;

        // Reset held with both requests high.
        for (int i = 0; i < 3; i++) begin
            cycle_in(1'b0, 1'b0, 1'b1, 18'h00100, 1'b1, 18'h0A000);
            check("rst_bg_gnt",  bg_gnt,     1'b0);
            check("rst_obj_gnt", obj_gnt,    1'b0);
            check("rst_bg_rv",   bg_rvalid,  1'b0);
            check("rst_obj_rv",  obj_rvalid, 1'b0);
            check("rst_rom_addr", rom_addr,  18'h0);
            check("rst_starve",  starve_cnt, 8'd0);
        end

        // Release: BG wins immediately, then streams incrementing addresses.
        for (int k = 0; k < 8; k++) begin
            cycle_in(1'b1, 1'b0, 1'b1, 18'(18'h00100 + k), k == 0, 18'h0A000);
            check("av_bg_gnt", bg_gnt, 1'b1);
            check("av_rom_addr", rom_addr, 18'(18'h00100 + k));
            if (k == 2) check("av_first_data", rd_data, 16'hA4A5);
            if (k >= 2) begin
                check("av_bg_rv", bg_rvalid, 1'b1);
                check("av_data", rd_data, 16'(16'h0100 + k - 2) ^ 16'hA5A5);
            end
        end

        // Starvation override: forced OBJ slots on cycles 9 and 18.
        for (int i = 1; i <= 20; i++) begin
            cycle_in(1'b1, 1'b0, 1'b1, 18'(18'h00200 + i), 1'b1, 18'h0A000);
            check("sv_starve", starve_cnt, 8'((i - 1) % 9));
            check("sv_obj_gnt", obj_gnt, (i % 9) == 0);
            check("sv_bg_gnt", bg_gnt, (i % 9) != 0);
            if (i % 9 == 0) check("sv_rom_addr", rom_addr, 18'h0A000);
            if (i == 11 || i == 20) begin
                check("sv_obj_rv", obj_rvalid, 1'b1);
                check("sv_obj_data", rd_data, 16'h05A5);
            end
        end

        // Blanking: OBJ wins, no starvation.
        for (int i = 1; i <= 6; i++) begin
            cycle_in(1'b1, 1'b1, 1'b1, 18'h00300, 1'b1, 18'(18'h0A100 + i));
            check("bk_obj_gnt", obj_gnt, 1'b1);
            check("bk_bg_gnt", bg_gnt, 1'b0);
            if (i > 1) check("bk_starve", starve_cnt, 8'd0);
        end
        cycle_in(1'b1, 1'b0, 1'b1, 18'h00300, 1'b1, 18'h0A107);
        check("bf_bg_gnt", bg_gnt, 1'b1);
        check("bf_obj_gnt", obj_gnt, 1'b0);

        // Forced slot with OBJ withdrawing its request.
        cycle_in(1'b1, 1'b0, 1'b1, 18'h00301, 1'b0, 18'h0A200);
        for (int i = 1; i <= 8; i++) begin
            cycle_in(1'b1, 1'b0, 1'b1, 18'(18'h00301 + i), 1'b1, 18'h0A200);
            check("fw_starve", starve_cnt, 8'(i - 1));
        end
        cycle_in(1'b1, 1'b0, 1'b1, 18'h00310, 1'b0, 18'h0A200);
        check("fw_bg_gnt", bg_gnt, 1'b0);
        check("fw_obj_gnt", obj_gnt, 1'b0);
        check("fw_starve_hold", starve_cnt, 8'd8);
        cycle_in(1'b1, 1'b0, 1'b1, 18'h00310, 1'b0, 18'h0A200);
        check("fw_bg_next", bg_gnt, 1'b1);
        check("fw_starve_clr", starve_cnt, 8'd0);

        // Idle drain, then mid-flight reset.
        for (int i = 0; i < 3; i++) cycle_in(1'b1, 1'b0, 1'b0, 18'h00310, 1'b0, 18'h0A200);
        check("idle_rom_hold", rom_addr, 18'h00310);
        cycle_in(1'b1, 1'b0, 1'b1, 18'h01234, 1'b0, 18'h0A200);
        check("mf_bg_gnt", bg_gnt, 1'b1);
        cycle_in(1'b0, 1'b0, 1'b1, 18'h01234, 1'b1, 18'h0A200);
        check("mf_rst_bg_gnt", bg_gnt, 1'b0);
        check("mf_rst_obj_gnt", obj_gnt, 1'b0);
        check("mf_rst_rom_addr", rom_addr, 18'h0);
        check("mf_rst_bg_rv", bg_rvalid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle_in(1'b1, 1'b0, 1'b0, 18'h01234, 1'b0, 18'h0A200);
            check("mf_no_bg_rv", bg_rvalid, 1'b0);
            check("mf_rom_addr", rom_addr, 18'h0);
        end

        // One plain OBJ read after reset to show the return path recovered.
        cycle_in(1'b1, 1'b0, 1'b0, 18'h01234, 1'b1, 18'h0B0B0);
        check("pr_obj_gnt", obj_gnt, 1'b1);
        cycle_in(1'b1, 1'b0, 1'b0, 18'h01234, 1'b0, 18'h0B0B0);
        cycle_in(1'b1, 1'b0, 1'b0, 18'h01234, 1'b0, 18'h0B0B0);
        check("pr_obj_rv", obj_rvalid, 1'b1);
        check("pr_obj_data", rd_data, 16'h1515);
        cycle_in(1'b1, 1'b0, 1'b0, 18'h01234, 1'b0, 18'h0B0B0);

        @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
- Shares the single-port sprite pixel ROM (18-bit address, 16-bit RGB565-style word, registered read) between two requesters: the background tile renderer (BG) and the moving-object overlay fetcher (OBJ, for Mario/enemies).
- Sits between both requesters and the sprite ROM instance.
- Grants at most one read per cycle and returns read-valid strobes aligned to ROM latency.
- Gives BG priority during active video and OBJ priority during blanking, with an anti-starvation override for OBJ.

Parameters:
- ADDR_W, 18, sprite ROM address width.
- DATA_W, 16, sprite ROM data width.
- ROM_LAT, 1, cycles from address presented (grant cycle) to valid rom_data; legal range 1..4.
- STARVE_MAX, 8, consecutive denied OBJ cycles before a forced OBJ grant; legal range 1..255.

Ports:
- clk, in, 1: system/pixel clock.
- rst, in, 1: reset; synchronous, active-low.
- blank, in, 1: 1 during horizontal or vertical blanking (inactive video).
- bg_req, in, 1: BG read request; held with bg_addr stable until granted.
- bg_addr, in, ADDR_W: BG read address.
- bg_gnt, out, 1: BG request accepted this cycle.
- bg_rvalid, out, 1: rd_data holds the BG read result.
- obj_req, in, 1: OBJ read request; same hold rule as bg_req.
- obj_addr, in, ADDR_W: OBJ read address.
- obj_gnt, out, 1: OBJ request accepted this cycle.
- obj_rvalid, out, 1: rd_data holds the OBJ read result.
- rom_addr, out, ADDR_W: address to the sprite ROM.
- rom_data, in, DATA_W: sprite ROM read data.
- rd_data, out, DATA_W: shared return data, equal to rom_data.
- starve_cnt, out, 8: current OBJ denial count (debug/verification visibility).

Behaviour:
- Reset (rst=0 at a clk edge):
  - starve_cnt=0, FSM=NORMAL, rvalid tag pipeline cleared.
  - While rst=0: bg_gnt=obj_gnt=0, rom_addr=0, bg_rvalid=obj_rvalid=0.
  - Any read in flight when reset asserts is dropped; no rvalid is issued for it after reset releases.
- Grant logic is combinational from req, blank, and FSM state. At most one gnt is high per cycle.
- FSM NORMAL:
  - blank=0: bg_req wins. obj_gnt = obj_req & ~bg_req.
  - blank=1: obj_req wins. bg_gnt = bg_req & ~obj_req.
- FSM FORCE_OBJ:
  - obj_gnt = obj_req and bg_gnt = 0, regardless of blank.
  - Next state is NORMAL unconditionally. This lasts exactly one cycle.
- starve_cnt update, per cycle:
  - Set to 0 when obj_req=0 or obj_gnt=1.
  - Incremented (saturating at 255) when obj_req=1 and obj_gnt=0.
  - When the incremented value would equal STARVE_MAX: next FSM = FORCE_OBJ and starve_cnt stays at STARVE_MAX. It returns to 0 on the forced grant.
- If obj_req drops while in FORCE_OBJ: no grant to anyone that cycle; return to NORMAL; starve_cnt=0.
- rom_addr: bg_addr when bg_gnt, obj_addr when obj_gnt, otherwise holds its previous value (this avoids ROM address toggling).
- Return path:
  - A 2-bit tag {bg,obj} is shifted through a ROM_LAT-deep register pipeline.
  - bg_rvalid/obj_rvalid assert exactly ROM_LAT cycles after the corresponding gnt cycle, for one cycle.
  - Back-to-back grants give back-to-back rvalids in grant order.
- rd_data = rom_data (pure pass-through). Consumers sample it only while their rvalid is high.
- Requests are not queued. A denied requester keeps req high. The arbiter never grants a request that was dropped in the same cycle.
- Simultaneous blank edge and force condition: FORCE_OBJ overrides blank-based priority.

Test Plan:
- Reset: hold rst=0 for 3 cycles with both req=1 -> both gnt=0, both rvalid=0, rom_addr=0, starve_cnt=0. Then release -> first grant goes to BG (blank=0) in the same cycle.
- Active-video priority: blank=0, bg_req=1 continuously with bg_addr incrementing from 0x00100, obj_req=0 -> bg_gnt=1 every cycle; bg_rvalid=1 from cycle ROM_LAT onward; rd_data matches ROM contents at 0x00100, 0x00101, … in order.
- Starvation override: blank=0, STARVE_MAX=8, bg_req=obj_req=1 for 20 cycles, obj_addr=0x0A000 -> starve_cnt counts 1..8; obj_gnt=1 on cycles 9 and 18 with bg_gnt=0 on those cycles; rom_addr=0x0A000 on those cycles; obj_rvalid ROM_LAT cycles after each.
- Blanking priority: blank=1, bg_req=obj_req=1 -> obj_gnt=1 every cycle, bg_gnt=0, starve_cnt stays 0. On blank falling -> BG granted in the same cycle.
- Mid-flight reset: grant BG at cycle N with ROM_LAT=2; assert rst=0 at cycle N+1 -> bg_rvalid never asserts for that read; all outputs at reset values.
- Forced grant with withdrawn request: reach starve_cnt=STARVE_MAX, then drop obj_req in the FORCE_OBJ cycle -> bg_gnt=0, obj_gnt=0 that cycle; starve_cnt=0; BG granted the next cycle.
